// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and helpers for the two-port register bank arbiter.
// State codes keep the historic IDLE=0, ACCESS=1, TURN=2 encoding.
package reg_bank_arbiter_pkg;

  localparam int unsigned RBA_DATA_WIDTH = 8;
  localparam int unsigned RBA_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    RBA_IDLE   = 2'd0,
    RBA_ACCESS = 2'd1,
    RBA_TURN   = 2'd2
  } rba_state_e;

  // Port 0 wins a tie when the previous winner was port 1, and vice versa.
  function automatic logic rba_pick(input logic req0, input logic req1, input logic rr_last);
    if (req0 && req1) return ~rr_last;
    return req1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester handshake and bank control pins of the arbiter.
// The bank data bus is a tristate and stays a plain inout on the top module.
interface reg_bank_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);

  logic                  req0;
  logic                  req1;
  logic                  rdwr0;
  logic                  rdwr1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;

  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  rb_cs;
  logic                  rb_rd_wr;
  logic [ADDR_WIDTH-1:0] rb_address;

  modport slave (
    input  req0, req1, rdwr0, rdwr1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata0, rdata1,
    output rb_cs, rb_rd_wr, rb_address
  );

  modport master (
    output req0, req1, rdwr0, rdwr1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1,
    input  rb_cs, rb_rd_wr, rb_address
  );

endinterface

// File: rtl/reg_bank_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between the pending requests.
module rr_arb2
  import reg_bank_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_last,
  output logic o_win_valid,
  output logic o_win_id
);

  assign o_win_valid = i_req0 | i_req1;
  assign o_win_id    = rba_pick(i_req0, i_req1, i_rr_last);

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares the single-port register bank between two requesters, one fixed
// three-cycle access (IDLE -> ACCESS -> TURN) at a time.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = RBA_DATA_WIDTH,
  parameter int ADDR_WIDTH = RBA_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  reg_bank_arbiter_if.slave     io_bus,
  inout  wire  [DATA_WIDTH-1:0] io_rb_data
);

  rba_state_e            r_state;
  logic                  r_rr_last;
  logic                  r_win;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_done0;
  logic                  r_done1;
  logic                  r_cs;
  logic                  r_rd_wr;
  logic                  r_oe;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic                  w_win_valid;
  logic                  w_win_id;
  logic                  w_sel_rdwr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  rr_arb2 u_rr_arb2 (
    .i_req0      (io_bus.req0),
    .i_req1      (io_bus.req1),
    .i_rr_last   (r_rr_last),
    .o_win_valid (w_win_valid),
    .o_win_id    (w_win_id)
  );

  assign w_sel_rdwr  = w_win_id ? io_bus.rdwr1  : io_bus.rdwr0;
  assign w_sel_addr  = w_win_id ? io_bus.addr1  : io_bus.addr0;
  assign w_sel_wdata = w_win_id ? io_bus.wdata1 : io_bus.wdata0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= RBA_IDLE;
      r_rr_last <= 1'b1;
      r_win     <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_cs      <= 1'b0;
      r_rd_wr   <= 1'b0;
      r_oe      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      case (r_state)
        RBA_IDLE: begin
          if (w_win_valid) begin
            r_win   <= w_win_id;
            r_gnt0  <= ~w_win_id;
            r_gnt1  <= w_win_id;
            r_cs    <= 1'b1;
            r_rd_wr <= w_sel_rdwr;
            r_oe    <= ~w_sel_rdwr;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_state <= RBA_ACCESS;
          end
        end
        RBA_ACCESS: begin
          // On a read the bank is driving the bus during this cycle.
          if (r_rd_wr) begin
            if (r_win) r_rdata1 <= io_rb_data;
            else       r_rdata0 <= io_rb_data;
          end
          r_done0   <= ~r_win;
          r_done1   <= r_win;
          r_gnt0    <= 1'b0;
          r_gnt1    <= 1'b0;
          r_cs      <= 1'b0;
          r_rd_wr   <= 1'b0;
          r_oe      <= 1'b0;
          r_rr_last <= r_win;
          r_state   <= RBA_TURN;
        end
        RBA_TURN: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= RBA_IDLE;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_cs    <= 1'b0;
          r_oe    <= 1'b0;
          r_state <= RBA_IDLE;
        end
      endcase
    end
  end

  assign io_rb_data = r_oe ? r_wdata : 'z;

  assign io_bus.gnt0       = r_gnt0;
  assign io_bus.gnt1       = r_gnt1;
  assign io_bus.done0      = r_done0;
  assign io_bus.done1      = r_done1;
  assign io_bus.rdata0     = r_rdata0;
  assign io_bus.rdata1     = r_rdata1;
  assign io_bus.rb_cs      = r_cs;
  assign io_bus.rb_rd_wr   = r_rd_wr;
  assign io_bus.rb_address = r_addr;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench: arbiter plus an 8-entry behavioural register bank on the rb_* pins.
module tb_reg_bank_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   mon_bad = 0;

  wire  [7:0] rb_data;
  logic [7:0] mem [8] = '{default: 8'h00};
  logic       bank_oe;

  reg_bank_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bif ();

  reg_bank_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .io_bus     (bif),
    .io_rb_data (rb_data)
  );

  always #5 clk = ~clk;

  assign bank_oe = bif.rb_cs && bif.rb_rd_wr;
  assign rb_data = bank_oe ? mem[bif.rb_address] : 'z;

  always_ff @(posedge clk) begin
    if (bif.rb_cs && !bif.rb_rd_wr) mem[bif.rb_address] <= rb_data;
  end

  // Bus rules watched on every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.rb_cs && !(bif.gnt0 || bif.gnt1)) mon_bad++;
      if (dut.r_oe && !(bif.rb_cs && !bif.rb_rd_wr)) mon_bad++;
      if (bif.rb_cs && $isunknown(rb_data)) mon_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit p, input logic v, input logic rw,
                           input logic [2:0] a, input logic [7:0] d);
    if (p) begin
      bif.req1 = v; bif.rdwr1 = rw; bif.addr1 = a; bif.wdata1 = d;
    end else begin
      bif.req0 = v; bif.rdwr0 = rw; bif.addr0 = a; bif.wdata0 = d;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(dut.r_state), 32'd0);
    chk("rst_gnt", 32'({bif.gnt1, bif.gnt0}), 32'd0);
    chk("rst_done", 32'({bif.done1, bif.done0}), 32'd0);
    chk("rst_cs", 32'(bif.rb_cs), 32'd0);
    chk("rst_rd_wr", 32'(bif.rb_rd_wr), 32'd0);
    chk("rst_addr", 32'(bif.rb_address), 32'd0);
    chk("rst_rdata0", 32'(bif.rdata0), 32'd0);
    chk("rst_rdata1", 32'(bif.rdata1), 32'd0);
    chk("rst_oe", 32'(dut.r_oe), 32'd0);
    reset = 1'b0;
  endtask

  // Uncontended access: grant one cycle after req, done the cycle after that.
  task automatic access(input bit p, input logic rw, input logic [2:0] a, input logic [7:0] d);
    int cyc;
    bit seen;
    drive_req(p, 1'b1, rw, a, d);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      seen = p ? bif.gnt1 : bif.gnt0;
    end
    chk("gnt_latency", 32'(cyc), 32'd1);
    if (seen) begin
      chk("acc_cs", 32'(bif.rb_cs), 32'd1);
      chk("acc_rd_wr", 32'(bif.rb_rd_wr), 32'(rw));
      chk("acc_addr", 32'(bif.rb_address), 32'(a));
      chk("acc_oe", 32'(dut.r_oe), 32'(!rw));
      if (!rw) chk("acc_wbus", 32'(rb_data), 32'(d));
      @(negedge clk);
      chk("acc_done", 32'(p ? bif.done1 : bif.done0), 32'd1);
      chk("acc_gnt_off", 32'({bif.gnt1, bif.gnt0}), 32'd0);
      chk("acc_cs_off", 32'(bif.rb_cs), 32'd0);
    end
    drive_req(p, 1'b0, rw, a, d);
    @(negedge clk);
    chk("done_pulse", 32'({bif.done1, bif.done0}), 32'd0);
  endtask

  initial begin
    int t_g0, t_g1, ovl, n, k;
    int ids [6];
    int tms [6];
    logic [7:0] w [8];

    drive_req(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    reset_dut();

    // write A5 to addr 3 on port 0, read it back
    access(1'b0, 1'b0, 3'd3, 8'hA5);
    chk("t1_mem3", 32'(mem[3]), 32'hA5);
    chk("t1_wr_keeps_rdata0", 32'(bif.rdata0), 32'd0);
    access(1'b0, 1'b1, 3'd3, 8'h00);
    chk("t1_rdata0", 32'(bif.rdata0), 32'hA5);
    chk("t1_rdata1", 32'(bif.rdata1), 32'd0);

    // simultaneous requests straight after reset
    reset_dut();
    drive_req(1'b0, 1'b1, 1'b1, 3'd3, 8'h00);
    drive_req(1'b1, 1'b1, 1'b1, 3'd4, 8'h00);
    t_g0 = -1; t_g1 = -1; ovl = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (bif.gnt0 && t_g0 < 0) t_g0 = i;
      if (bif.gnt1 && t_g1 < 0) t_g1 = i;
      if (bif.gnt0 && bif.gnt1) ovl++;
      if (bif.done0) bif.req0 = 1'b0;
      if (bif.done1) bif.req1 = 1'b0;
    end
    chk("t2_gnt0_time", 32'(t_g0), 32'd1);
    chk("t2_gnt1_time", 32'(t_g1), 32'd4);
    chk("t2_overlap", 32'(ovl), 32'd0);
    chk("t2_rdata0", 32'(bif.rdata0), 32'hA5);
    chk("t2_rdata1", 32'(bif.rdata1), 32'd0);

    // both held for six accesses
    reset_dut();
    drive_req(1'b0, 1'b1, 1'b1, 3'd1, 8'h00);
    drive_req(1'b1, 1'b1, 1'b1, 3'd2, 8'h00);
    n = 0; k = 0;
    while (n < 6 && k < 40) begin
      @(negedge clk);
      k++;
      if (bif.gnt0 || bif.gnt1) begin
        ids[n] = int'(bif.gnt1);
        tms[n] = k;
        n++;
      end
    end
    chk("t3_grant_count", 32'(n), 32'd6);
    for (int i = 0; i < n; i++) chk($sformatf("t3_id%0d", i), 32'(ids[i]), 32'(i % 2));
    for (int i = 1; i < n; i++) chk($sformatf("t3_gap%0d", i), 32'(tms[i] - tms[i-1]), 32'd3);
    @(negedge clk);
    bif.req0 = 1'b0;
    bif.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // port 1 fills every register, then reads them back
    reset_dut();
    for (int a = 0; a < 8; a++) begin
      w[a] = 8'($urandom_range(0, 255));
      access(1'b1, 1'b0, 3'(a), w[a]);
      chk($sformatf("t4_wr%0d_rdata1", a), 32'(bif.rdata1), 32'd0);
    end
    for (int a = 0; a < 8; a++) begin
      access(1'b1, 1'b1, 3'(a), 8'h00);
      chk($sformatf("t4_rd%0d", a), 32'(bif.rdata1), 32'(w[a]));
      chk($sformatf("t4_rd%0d_rdata0", a), 32'(bif.rdata0), 32'd0);
    end

    // reset lands on a port 0 ACCESS cycle
    reset_dut();
    drive_req(1'b0, 1'b1, 1'b0, 3'd5, 8'h77);
    @(negedge clk);
    chk("t5_in_access", 32'(bif.gnt0), 32'd1);
    reset = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 3'd5, 8'h77);
    @(negedge clk);
    chk("t5_state", 32'(dut.r_state), 32'd0);
    chk("t5_cs", 32'(bif.rb_cs), 32'd0);
    chk("t5_gnt0", 32'(bif.gnt0), 32'd0);
    chk("t5_done0", 32'(bif.done0), 32'd0);
    chk("t5_oe", 32'(dut.r_oe), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_no_done_a", 32'(bif.done0), 32'd0);
    @(negedge clk);
    chk("t5_no_done_b", 32'(bif.done0), 32'd0);

    chk("bus_rules", 32'(mon_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
